// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Receives a program as a valid/ready byte stream and writes it into
//            the instruction memory, one IW-bit word per write strobe. Bytes
//            are packed MSB-first. A short final word is zero-filled. The CPU
//            is held in reset until a load completes cleanly.
// Ports    : clk, rst (async, active-high)
//            start                     - begin a load (honoured in IDLE/DONE)
//            in_valid/in_ready/in_data/in_last - program byte stream
//            mem_we/mem_addr/mem_wdata - imem write port
//            cpu_hold                  - keep CPU in reset while high
//            busy/done/err             - load status
//            word_count/checksum       - words written, mod-256 byte sum
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int IW = 16,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [IW-1:0] mem_wdata,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_count,
   output logic [7:0]    checksum
);

   localparam int BPW  = IW / 8;
   localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(BPW - 1);
   localparam logic [AW-1:0]   C_MAX_ADDR = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_word;
   logic [IDXW-1:0] r_byte_idx;
   logic            r_last;       // word being written carried in_last
   logic [AW:0]     r_word_count;
   logic [7:0]      r_checksum;
   logic            r_err;

   logic w_accept;
   logic w_word_end;
   logic w_restart;
   logic w_at_max;

   assign w_accept   = (r_state == S_LOAD) && in_valid;
   assign w_word_end = w_accept && (in_last || (r_byte_idx == C_LAST_IDX));
   assign w_restart  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
   assign w_at_max   = (r_word_count[AW-1:0] == C_MAX_ADDR);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  if (w_word_end) w_next = S_WRITE;
         S_WRITE: begin
            if (r_last || w_at_max) w_next = S_DONE;
            else                    w_next = S_LOAD;
         end
         S_DONE:  if (start) w_next = S_LOAD;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: word assembly, counters and status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word       <= '0;
         r_byte_idx   <= '0;
         r_last       <= 1'b0;
         r_word_count <= '0;
         r_checksum   <= '0;
         r_err        <= 1'b0;
      end else if (w_restart) begin
         r_word       <= '0;
         r_byte_idx   <= '0;
         r_last       <= 1'b0;
         r_word_count <= '0;
         r_checksum   <= '0;
         r_err        <= 1'b0;
      end else if (w_accept) begin
         r_checksum <= r_checksum + in_data;
         for (int b = 0; b < BPW; b++) begin
            if (r_byte_idx == IDXW'(b)) r_word[IW-1-8*b -: 8] <= in_data;
         end
         if (w_word_end) begin
            r_byte_idx <= '0;
            r_last     <= in_last;
            // Last byte landed before the word filled: short final word
            if (in_last && (r_byte_idx != C_LAST_IDX)) r_err <= 1'b1;
         end else begin
            r_byte_idx <= r_byte_idx + IDXW'(1);
         end
      end else if (r_state == S_WRITE) begin
         r_word_count <= r_word_count + 1'b1;
         // Clear so that a following short word has zero low bytes
         r_word       <= '0;
         r_last       <= 1'b0;
         // Memory full while the stream still has more to send
         if (!r_last && w_at_max) r_err <= 1'b1;
      end
   end

   assign in_ready   = (r_state == S_LOAD);
   assign mem_we     = (r_state == S_WRITE);
   assign mem_addr   = r_word_count[AW-1:0];
   assign mem_wdata  = r_word;
   assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;
   assign cpu_hold   = !((r_state == S_DONE) && !r_err);
   assign word_count = r_word_count;
   assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader. Main instance uses
//            IW=16/AW=8; a second IW=8/AW=2 instance covers address overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // Main instance (IW=16, AW=8)
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold, busy, done, err;
   logic [8:0]  word_count;
   logic [7:0]  checksum;

   // Small instance (IW=8, AW=2)
   logic        s_start = 1'b0;
   logic        s_in_valid = 1'b0;
   logic [7:0]  s_in_data = 8'h00;
   logic        s_in_last = 1'b0;
   logic        s_in_ready;
   logic        s_mem_we;
   logic [1:0]  s_mem_addr;
   logic [7:0]  s_mem_wdata;
   logic        s_cpu_hold, s_busy, s_done, s_err;
   logic [2:0]  s_word_count;
   logic [7:0]  s_checksum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imem_loader #(.IW(16), .AW(8)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
      .word_count(word_count), .checksum(checksum)
   );

   imem_loader #(.IW(8), .AW(2)) u_dut_small (
      .clk(clk), .rst(rst), .start(s_start),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .cpu_hold(s_cpu_hold), .busy(s_busy), .done(s_done), .err(s_err),
      .word_count(s_word_count), .checksum(s_checksum)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one byte; returns #1 after the handshake edge
   task automatic send_byte(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("rdy_wait", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [7:0] a, input logic [15:0] d);
      check({tag, "_we"},   {31'd0, mem_we}, 32'd1);
      check({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, a});
      check({tag, "_data"}, {16'd0, mem_wdata}, {16'd0, d});
      check({tag, "_rdy"},  {31'd0, in_ready}, 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_err"},  {31'd0, err}, 32'd0);
      check({tag, "_we"},   {31'd0, mem_we}, 32'd0);
      check({tag, "_rdy"},  {31'd0, in_ready}, 32'd0);
      check({tag, "_wc"},   {23'd0, word_count}, 32'd0);
      check({tag, "_cs"},   {24'd0, checksum}, 32'd0);
      check({tag, "_wd"},   {16'd0, mem_wdata}, 32'd0);
   endtask

   // Full clean load 0x12,0x34,0x56,0x78(last); gaps > 0 inserts idle cycles
   task automatic load_basic(input string tag, input int max_gap);
      logic [7:0] bytes [4];
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
      do_start();
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, max_gap)) tick();
         send_byte(bytes[i], (i == 3));
         if (i == 0) check({tag, "_nowe"}, {31'd0, mem_we}, 32'd0);
         if (i == 1) check_write({tag, "_w0"}, 8'd0, 16'h1234);
         if (i == 3) check_write({tag, "_w1"}, 8'd1, 16'h5678);
      end
      tick();
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_err"},  {31'd0, err}, 32'd0);
      check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_wc"},   {23'd0, word_count}, 32'd2);
      check({tag, "_cs"},   {24'd0, checksum}, 32'h14);
      check({tag, "_we0"},  {31'd0, mem_we}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #2;
      check_reset_outs("rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hold", {31'd0, cpu_hold}, 32'd1);

      // Clean two-word load
      load_basic("basic", 0);

      // Same load with idle gaps and bytes offered during WRITE
      load_basic("bp", 3);

      // Partial final word
      do_start();
      check("part_err0", {31'd0, err}, 32'd0);
      send_byte(8'hAB, 1'b0);
      send_byte(8'hCD, 1'b0);
      check_write("part_w0", 8'd0, 16'hABCD);
      send_byte(8'hEF, 1'b1);
      check_write("part_w1", 8'd1, 16'hEF00);
      tick();
      check("part_done", {31'd0, done}, 32'd1);
      check("part_err",  {31'd0, err}, 32'd1);
      check("part_hold", {31'd0, cpu_hold}, 32'd1);
      check("part_wc",   {23'd0, word_count}, 32'd2);
      check("part_cs",   {24'd0, checksum}, 32'h67);

      // Start ignored in LOAD, honoured in DONE
      do_start();
      check("st_err_clr", {31'd0, err}, 32'd0);
      send_byte(8'h12, 1'b0);
      do_start();
      check("st_ign_busy", {31'd0, busy}, 32'd1);
      check("st_ign_cs",   {24'd0, checksum}, 32'h12);
      send_byte(8'h34, 1'b0);
      check_write("st_w0", 8'd0, 16'h1234);
      send_byte(8'h56, 1'b0);
      send_byte(8'h78, 1'b1);
      check_write("st_w1", 8'd1, 16'h5678);
      tick();
      check("st_hold0", {31'd0, cpu_hold}, 32'd0);
      do_start();
      check("st_wc",   {23'd0, word_count}, 32'd0);
      check("st_cs",   {24'd0, checksum}, 32'd0);
      check("st_err",  {31'd0, err}, 32'd0);
      check("st_hold", {31'd0, cpu_hold}, 32'd1);
      check("st_busy", {31'd0, busy}, 32'd1);

      // Reset mid-load, after the first byte of the second word
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outs("mrst");
      tick();
      check("mrst_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      check("mrst_idle", {31'd0, busy}, 32'd0);
      check("mrst_we2",  {31'd0, mem_we}, 32'd0);
      load_basic("reload", 0);

      // Address overflow on the small instance
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("ov_rdy", {31'd0, s_in_ready}, 32'd1);
         s_in_valid = 1'b1;
         s_in_data  = 8'(i + 1);
         s_in_last  = 1'b0;
         tick();
         s_in_valid = 1'b0;
         check("ov_we",   {31'd0, s_mem_we}, 32'd1);
         check("ov_addr", {30'd0, s_mem_addr}, 32'(i));
         check("ov_data", {24'd0, s_mem_wdata}, 32'(i + 1));
         tick();
      end
      check("ov_done", {31'd0, s_done}, 32'd1);
      check("ov_err",  {31'd0, s_err}, 32'd1);
      check("ov_hold", {31'd0, s_cpu_hold}, 32'd1);
      check("ov_wc",   {29'd0, s_word_count}, 32'd4);
      s_in_valid = 1'b1;
      s_in_data  = 8'h05;
      s_in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("ov5_rdy", {31'd0, s_in_ready}, 32'd0);
         tick();
         check("ov5_we",  {31'd0, s_mem_we}, 32'd0);
      end
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
      check("ov5_cs", {24'd0, s_checksum}, 32'd10);
      check("ov5_wc", {29'd0, s_word_count}, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
